dsm2_mod: RTL and testbench

Second-order, single-bit delta-sigma modulator that converts the interpolated output of the CIC chain (`integrator` output, `WIDTH + GROWTH + SIGN` bits) into a pulse-density bitstream for the DAC output pin. It sits directly downstream of the CIC integrator and runs in the same `clk` domain, qualified by the shared `clk_en` strobe. It uses clamped accumulators and a stall watchdog, so it recovers on its own from overload instead of locking up.

---
 rtl/dsm2_mod.sv | 157 +++++++++++++++
 tb/tb_dsm2_mod.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dsm2_mod.sv
// ---------------------------------------------------------------------------
// dsm2_mod : second-order, single-bit delta-sigma modulator.
//
// Turns the signed output of the CIC interpolator into a pulse-density
// bitstream for the DAC pin. Both integrators saturate instead of wrapping,
// and a watchdog restarts the loop after a long run of identical output bits.
// Together these let the modulator recover from overload by itself.
//
// Parameters
//   IN_WIDTH    : signed input width (CIC output width)
//   ACC_GUARD   : extra integrator bits above IN_WIDTH
//   STALL_LIMIT : identical consecutive output bits that trigger a restart (>= 2)
//
// Ports
//   clk     : system clock
//   rst     : asynchronous, active-high reset
//   clk_en  : update strobe; all state advances only when it is high
//   in      : signed two's-complement sample, taken on update edges
//   pdm_out : modulator bit (1 = +FB fed back, 0 = -FB fed back)
//   sat     : an integrator clamped during the most recent update
//   restart : the watchdog cleared the loop during the most recent update
// ---------------------------------------------------------------------------
module dsm2_mod #(
  parameter int IN_WIDTH    = 24,
  parameter int ACC_GUARD   = 4,
  parameter int STALL_LIMIT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_en,
  input  logic signed [IN_WIDTH-1:0] in,
  output logic                       pdm_out,
  output logic                       sat,
  output logic                       restart
);

  localparam int ACC_WIDTH = IN_WIDTH + ACC_GUARD;
  // Two headroom bits: the worst-case sum of a full-scale integrator, the
  // other integrator (or the input) and the feedback cannot wrap.
  localparam int EXT_WIDTH = ACC_WIDTH + 2;
  localparam int CNT_WIDTH = $clog2(STALL_LIMIT + 1);

  localparam logic signed [EXT_WIDTH-1:0] FB_POS = EXT_WIDTH'(1) << (IN_WIDTH - 2);
  localparam logic signed [EXT_WIDTH-1:0] FB_NEG = -FB_POS;

  // Clamp limits in the extended domain and in the accumulator domain.
  localparam logic signed [EXT_WIDTH-1:0] MAX_X = {3'b000, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_WIDTH-1:0] MIN_X = {3'b111, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] MAX_ACC = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_ACC = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STALL_LIMIT);

  // Registered state
  logic signed [ACC_WIDTH-1:0] acc1_q, acc2_q;
  logic                        pdm_q, sat_q, restart_q;
  logic [CNT_WIDTH-1:0]        run_q;

  // Next-state values
  logic signed [ACC_WIDTH-1:0] acc1_d, acc2_d;
  logic                        pdm_d, sat_d, restart_d;
  logic [CNT_WIDTH-1:0]        run_d;

  // Datapath intermediates
  logic signed [EXT_WIDTH-1:0] in_x, acc1_x, acc2_x, fb_x, sum1, sum2;
  logic signed [ACC_WIDTH-1:0] a1n, a2n;
  logic                        clip1, clip2, ybit;
  logic [CNT_WIDTH-1:0]        run_inc;

  function automatic logic signed [ACC_WIDTH-1:0] clamp_acc(
    input logic signed [EXT_WIDTH-1:0] v
  );
    if (v > MAX_X)      return MAX_ACC;
    else if (v < MIN_X) return MIN_ACC;
    else                return v[ACC_WIDTH-1:0];
  endfunction

  always_comb begin
    // NOTE: every variable gets a default at the top of the block, so no path
    // can leave one unassigned and infer a latch.
    in_x      = '0;
    acc1_x    = '0;
    acc2_x    = '0;
    fb_x      = FB_NEG;
    sum1      = '0;
    sum2      = '0;
    a1n       = '0;
    a2n       = '0;
    clip1     = 1'b0;
    clip2     = 1'b0;
    ybit      = 1'b0;
    run_inc   = '0;
    acc1_d    = acc1_q;
    acc2_d    = acc2_q;
    pdm_d     = pdm_q;
    run_d     = run_q;
    sat_d     = 1'b0;
    restart_d = 1'b0;

    in_x   = {{(EXT_WIDTH-IN_WIDTH){in[IN_WIDTH-1]}}, in};
    acc1_x = {{2{acc1_q[ACC_WIDTH-1]}}, acc1_q};
    acc2_x = {{2{acc2_q[ACC_WIDTH-1]}}, acc2_q};
    fb_x   = pdm_q ? FB_POS : FB_NEG;

    // Both integrators update from the old register values.
    sum1  = acc1_x + in_x - fb_x;
    sum2  = acc2_x + acc1_x - fb_x;
    clip1 = (sum1 > MAX_X) || (sum1 < MIN_X);
    clip2 = (sum2 > MAX_X) || (sum2 < MIN_X);
    a1n   = clamp_acc(sum1);
    a2n   = clamp_acc(sum2);
    ybit  = ~a2n[ACC_WIDTH-1];
    sat_d = clip1 | clip2;

    run_inc = (run_q == LIMIT) ? run_q : run_q + CNT_WIDTH'(1);

    if (ybit == pdm_q && run_inc == LIMIT) begin
      // Output stuck for STALL_LIMIT updates: clear the loop and start over.
      acc1_d    = '0;
      acc2_d    = '0;
      pdm_d     = 1'b0;
      run_d     = '0;
      restart_d = 1'b1;
    end else begin
      acc1_d    = a1n;
      acc2_d    = a2n;
      pdm_d     = ybit;
      run_d     = (ybit != pdm_q) ? CNT_WIDTH'(1) : run_inc;
      restart_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc1_q    <= '0;
      acc2_q    <= '0;
      pdm_q     <= 1'b0;
      run_q     <= '0;
      sat_q     <= 1'b0;
      restart_q <= 1'b0;
    end else if (clk_en) begin
      acc1_q    <= acc1_d;
      acc2_q    <= acc2_d;
      pdm_q     <= pdm_d;
      run_q     <= run_d;
      sat_q     <= sat_d;
      restart_q <= restart_d;
    end
  end

  assign pdm_out = pdm_q;
  assign sat     = sat_q;
  assign restart = restart_q;

endmodule

// File: tb/tb_dsm2_mod.sv
// ---------------------------------------------------------------------------
// tb_dsm2_mod : directed self-checking bench for dsm2_mod (default parameters).
// Expected values are hand-derived in units of FB = 2^22:
//   zero input   -> pdm 1,1,1,0,0,0,0,1 repeating; (acc1,acc2) = (1,1) after
//                   update 1 and (-2,-2) after update 4
//   FB/4 input   -> ~0.625 ones density
//   max input    -> acc2 clamps at update 8, watchdog fires on updates 64, 128
// ---------------------------------------------------------------------------
module tb_dsm2_mod;

  localparam int IN_W = 24;
  localparam int FB   = 1 << (IN_W - 2);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   clk_en;
  logic signed [IN_W-1:0] in_s;
  logic                   pdm_out, sat, restart;

  int checks = 0;
  int errors = 0;

  int zbits [8] = '{1, 1, 1, 0, 0, 0, 0, 1};

  dsm2_mod #(.IN_WIDTH(IN_W), .ACC_GUARD(4), .STALL_LIMIT(64)) dut (
    .clk     (clk),
    .rst     (rst),
    .clk_en  (clk_en),
    .in      (in_s),
    .pdm_out (pdm_out),
    .sat     (sat),
    .restart (restart)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    clk_en = 1'b0;
    in_s   = '0;
    tick();
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  // Zero-input run at full rate from a freshly reset modulator.
  task automatic run_zero(input string tag, input int n_upd);
    clk_en = 1'b1;
    in_s   = '0;
    for (int n = 1; n <= n_upd; n++) begin
      tick();
      check($sformatf("%s_pdm[%0d]", tag, n), pdm_out, zbits[(n-1)%8]);
      check($sformatf("%s_sat[%0d]", tag, n), sat, 0);
      check($sformatf("%s_restart[%0d]", tag, n), restart, 0);
      if (n == 1) begin
        check({tag, "_acc1_u1"}, $signed(dut.acc1_q), FB);
        check({tag, "_acc2_u1"}, $signed(dut.acc2_q), FB);
      end
      if (n == 4) begin
        check({tag, "_acc1_u4"}, $signed(dut.acc1_q), -2 * FB);
        check({tag, "_acc2_u4"}, $signed(dut.acc2_q), -2 * FB);
      end
    end
  endtask

  initial begin
    int upd;
    int ones;
    int exp_pdm;
    bit seen_sat;
    bit seen_restart;
    bit exp_rs;

    // ---- Reset state ----
    rst    = 1'b1;
    clk_en = 1'b0;
    in_s   = '0;
    tick();
    check("reset_pdm", pdm_out, 0);
    check("reset_sat", sat, 0);
    check("reset_restart", restart, 0);
    @(posedge clk);
    #3 rst = 1'b0;

    // ---- Zero input, full rate; 25 updates leave pdm_out = 1 ----
    run_zero("zero", 25);

    // ---- Async reset between edges, then held across an enabled edge ----
    #3 rst = 1'b1;
    #1;
    check("async_pdm", pdm_out, 0);
    check("async_sat", sat, 0);
    check("async_restart", restart, 0);
    check("async_acc1", $signed(dut.acc1_q), 0);
    tick();
    check("async_hold_pdm", pdm_out, 0);
    #3 rst = 1'b0;
    run_zero("after_rst", 16);

    // ---- Gated updates: clk_en every 5th cycle, junk input while disabled ----
    do_reset();
    upd     = 0;
    exp_pdm = 0;
    for (int c = 0; c < 80; c++) begin
      clk_en = (c % 5 == 4);
      in_s   = clk_en ? '0 : IN_W'($urandom());
      tick();
      if (clk_en) begin
        upd++;
        exp_pdm = zbits[(upd-1)%8];
        check($sformatf("gated_pdm[%0d]", upd), pdm_out, exp_pdm);
      end else begin
        check($sformatf("gated_hold[%0d]", c), pdm_out, exp_pdm);
        check($sformatf("gated_sat[%0d]", c), sat, 0);
      end
    end

    // ---- DC density: in = FB/4 for 4096 updates ----
    do_reset();
    clk_en       = 1'b1;
    in_s         = IN_W'(FB / 4);
    ones         = 0;
    seen_sat     = 1'b0;
    seen_restart = 1'b0;
    for (int n = 0; n < 4096; n++) begin
      tick();
      ones         += int'(pdm_out);
      seen_sat     |= sat;
      seen_restart |= restart;
    end
    check("dc_ones_in_2520_2600", (ones >= 2520 && ones <= 2600), 1);
    check("dc_no_sat", seen_sat, 0);
    check("dc_no_restart", seen_restart, 0);

    // ---- Overload: in = max positive held ----
    do_reset();
    clk_en   = 1'b1;
    in_s     = {1'b0, {(IN_W-1){1'b1}}};
    seen_sat = 1'b0;
    for (int n = 1; n <= 130; n++) begin
      tick();
      seen_sat |= sat;
      exp_rs = (n == 64 || n == 128);
      check($sformatf("ovl_restart[%0d]", n), restart, exp_rs);
      check($sformatf("ovl_pdm[%0d]", n), pdm_out, !exp_rs);
      if (n == 7)  check("ovl_no_sat_u7", sat, 0);
      if (n == 8)  check("ovl_sat_u8", sat, 1);
      if (n == 12) check("ovl_sat_by_u12", seen_sat, 1);
      if (n == 64) check("ovl_sat_on_restart", sat, 1);
      if (n == 64) check("ovl_acc1_cleared", $signed(dut.acc1_q), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
